// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from one 16-bit slice adder, one slice per clock.
// Operands enter and results leave through valid/ready handshakes.
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] result,
    output logic                carry_out,
    output logic                overflow
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          carry_out_q, carry_out_d;
    logic          overflow_q, overflow_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [15:0]   a_sl;
    logic [15:0]   b_sl;
    logic [16:0]   sum17;
    logic          accept;
    logic          last;

    assign accept = in_valid & in_ready_q;
    assign last   = (idx_q == LAST);

    // State register and all datapath flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: accept, walk the slices, then wait for the consumer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared 16-bit slice adder fed by the current slice and chained carry
    always_comb begin
        a_sl  = a_q[16*idx_q +: 16];
        b_sl  = b_q[16*idx_q +: 16];
        sum17 = {1'b0, a_sl} + {1'b0, b_sl} + {16'd0, carry_q};
    end

    // Datapath updates and registered handshake outputs
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        if (state_q == IDLE && accept) begin
            a_d      = op_a;
            b_d      = op_b ^ {W{sub}};
            carry_d  = sub;
            idx_d    = '0;
            result_d = '0;
        end else if (state_q == RUN) begin
            result_d[16*idx_q +: 16] = sum17[15:0];
            carry_d = sum17[16];
            idx_d   = idx_q + 1'b1;
            if (last) begin
                carry_out_d = sum17[16];
                // carry into the MSB recovered from the MSB sum bit
                overflow_d  = a_sl[15] ^ b_sl[15] ^ sum17[15] ^ sum17[16];
            end
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequential wide-operand adder/subtractor that splits two `16*WORDS`-bit operands into 16-bit slices. It drives them LSB-first through a single combinational 16-bit slice adder (A + B + Cin → Sum, Carry), one slice per clock. The slice carry is registered and chained into the next slice. The block sits directly around the team's 16-bit lookahead adder: it feeds that adder's inputs and consumes its Sum/Carry outputs, so wide additions reuse one 16-bit datapath. Upstream and downstream connect through valid/ready handshakes.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Operand width is `16*WORDS`. Legal range 2–16.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operands and `sub` are valid.
- `in_ready`  out  1: block can accept an operation. Registered; reset value 1.
- `op_a`  in  `16*WORDS`: operand A.
- `op_b`  in  `16*WORDS`: operand B.
- `sub`  in  1: 0 computes A+B; 1 computes A−B.
- `out_valid`  out  1: result valid. Registered; reset value 0.
- `out_ready`  in  1: downstream accepts the result.
- `result`  out  `16*WORDS`: sum or difference. Reset value 0.
- `carry_out`  out  1: carry out of the top slice. For subtraction, 1 means no borrow. Reset value 0.
- `overflow`  out  1: two's-complement signed overflow. Reset value 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `op_a` and `op_b ^ {16*WORDS{sub}}`.
  - Set the carry register to `sub`, clear the slice index, and go to RUN.
  - `in_ready` falls on the same edge.
- **RUN**
  - Each cycle, the slice adder takes slice `idx` of latched A, slice `idx` of latched B', and the carry register.
  - On the edge: Sum is written to `result[16*idx +: 16]`, Carry is written to the carry register, and `idx` increments.
  - After slice `WORDS-1` is written, go to DONE.
  - On that same edge, set `carry_out` = top-slice Carry, set `overflow` = carry into bit `16*WORDS-1` XOR top-slice Carry, and raise `out_valid`.
  - Carry into the MSB equals `A[msb] ^ B'[msb] ^ Sum[msb]`.
- **DONE**
  - `out_valid`=1. `result`, `carry_out` and `overflow` hold stable.
  - On `out_valid & out_ready`: drop `out_valid`, raise `in_ready`, and go to IDLE.
- `result` is cleared to 0 when an operation is accepted. Partially written slices are therefore never stale data from a previous operation.
- `in_valid` outside IDLE is ignored. No operand is captured and no state changes.
- Arithmetic is modulo 2^(16*WORDS). No saturation.
- Reset mid-operation: on any edge with `rst`=1, all state returns to IDLE and outputs return to their reset values. The in-flight operation is discarded with no partial output. `rst` overrides any simultaneous handshake.

## Timing
- Accept edge T0: `in_valid & in_ready` is sampled high.
- Slices 0 … WORDS-1 are written on edges T0+1 … T0+WORDS.
- `out_valid` is high from edge T0+WORDS. Latency is WORDS cycles from accept to `out_valid`.
- If `out_ready` is already high, the output handshake completes at edge T0+WORDS+1, and `in_ready` is high from that edge.
- The next accept can occur at edge T0+WORDS+2. Maximum throughput is one operation per WORDS+2 cycles.
- The slice-adder path (mux, adder, carry register) is the only combinational path longer than a gate. No input-to-output combinational paths exist.

## Test plan
Directed scenarios, with WORDS=4:
- **Full carry ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 → result=0, carry_out=1, overflow=0, `out_valid` first high exactly 4 cycles after accept.
- **Signed overflow:** A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → result=0x8000_0000_0000_0000, carry_out=0, overflow=1.
- **Subtract with borrow:** A=5, B=7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0. Then A=7, B=5, sub=1 → result=2, carry_out=1.
- **Inter-slice chaining:** A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001 → result=0x0001_0000_0001_0000, carry_out=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` and pulse `in_valid` with new operands. Required: `out_valid` stays 1, `result`/`carry_out`/`overflow` stay stable, `in_ready` stays 0, and the new operands are not captured. Release `out_ready` → handshake completes and `in_ready`=1 on the next edge.
- **Reset mid-RUN:** assert `rst` for 1 cycle after 2 slices are written. Required: next cycle `out_valid`=0, `result`=0, `carry_out`=0, `overflow`=0, `in_ready`=1. The following operation 3+4 returns 7 with normal latency.
